// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake
// and holds each instruction for decode until the core acknowledges it.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fault,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        w_target_aligned;

  assign w_target_aligned = (redirect_target[1:0] == 2'b00);

  // Fetch/hold sequencing; PC, held word and retire count only move on handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC_ALIGNED;
      r_instr <= NOP_INSTR;
      r_count <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
          end else begin
            r_state <= FETCH;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            r_count <= r_count + 32'd1;
            if (!redirect) begin
              r_pc    <= r_pc + 32'd4;
              r_state <= FETCH;
            end else if (w_target_aligned) begin
              r_pc    <= {redirect_target[31:2], 2'b00};
              r_state <= FETCH;
            end else begin
              r_state <= FAULT;
            end
          end else begin
            r_state <= HOLD;
          end
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign instr_valid = (r_state == HOLD);
  assign fault       = (r_state == FAULT);
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, wait states, hold/redirect,
// misaligned fault, PC wrap (second instance) and reset during a fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_ready, imem_ready2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] instruction, instruction2;
  logic [31:0] pc, pc2;
  logic        instr_valid, instr_valid2;
  logic        instr_ack, instr_ack2;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fault, fault2;
  logic [31:0] instr_count, instr_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Zero-wait memory content: each word is its address tagged with A in the top nibble.
  assign imem_rdata  = imem_addr | 32'hA000_0000;
  assign imem_rdata2 = 32'h1234_5678;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .redirect(redirect), .redirect_target(redirect_target),
    .fault(fault), .instr_count(instr_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
    .instruction(instruction2), .pc(pc2), .instr_valid(instr_valid2),
    .instr_ack(instr_ack2), .redirect(1'b0), .redirect_target(32'h0000_0000),
    .fault(fault2), .instr_count(instr_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    imem_ready = 1'b0; imem_ready2 = 1'b1;
    instr_ack = 1'b0; instr_ack2 = 1'b1;
    redirect = 1'b0; redirect_target = 32'h0000_0000;
    tick(); tick();

    // Reset state
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_count", instr_count, 32'd0);

    // Sequential fetch with zero-wait memory and ack held high
    rst = 1'b0;
    tick();
    check("seq_req0", {31'd0, imem_req}, 32'd1);
    check("seq_addr0", imem_addr, 32'h0000_0000);
    imem_ready = 1'b1; instr_ack = 1'b1;
    tick();
    check("seq_valid0", {31'd0, instr_valid}, 32'd1);
    check("seq_instr0", instruction, 32'hA000_0000);
    check("seq_pc0", pc, 32'h0000_0000);
    check("seq_hold_req0", {31'd0, imem_req}, 32'd0);
    tick();
    check("seq_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("seq_addr1", imem_addr, 32'h0000_0004);
    tick();
    check("seq_instr1", instruction, 32'hA000_0004);
    check("seq_pc1", pc, 32'h0000_0004);
    tick();
    tick();
    check("seq_instr2", instruction, 32'hA000_0008);
    check("seq_pc2", pc, 32'h0000_0008);
    tick();
    check("seq_count3", instr_count, 32'd3);
    check("seq_addr3", imem_addr, 32'h0000_000C);

    // Wait states: ready withheld for 3 more cycles
    imem_ready = 1'b0; instr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_req", {31'd0, imem_req}, 32'd1);
      check("ws_addr", imem_addr, 32'h0000_000C);
      check("ws_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("ws_valid_rise", {31'd0, instr_valid}, 32'd1);
    check("ws_instr", instruction, 32'hA000_000C);

    // Hold with ack withheld; redirect pulse without ack is ignored
    for (int i = 0; i < 5; i++) begin
      redirect = (i == 1); redirect_target = 32'h0000_0200;
      tick();
      check("hold_instr", instruction, 32'hA000_000C);
      check("hold_pc", pc, 32'h0000_000C);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0100;
    tick();
    instr_ack = 1'b0; redirect = 1'b0;
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_count", instr_count, 32'd4);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("redir_instr", instruction, 32'hA000_0100);

    // Misaligned redirect target -> sticky fault
    instr_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0102;
    tick();
    instr_ack = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
    check("flt_fault", {31'd0, fault}, 32'd1);
    check("flt_count", instr_count, 32'd5);
    check("flt_pc", pc, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flt_req", {31'd0, imem_req}, 32'd0);
      check("flt_valid", {31'd0, instr_valid}, 32'd0);
      check("flt_sticky", {31'd0, fault}, 32'd1);
    end
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("flt_rst_fault", {31'd0, fault}, 32'd0);
    check("flt_rst_pc", pc, 32'h0000_0000);
    check("flt_rst_count", instr_count, 32'd0);
    tick();

    // Reset during a pending fetch, then a late ready in the IDLE cycle
    rst = 1'b0;
    tick();
    check("mid_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_abandon", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("mid_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_req2", {31'd0, imem_req}, 32'd1);
    check("mid_addr", imem_addr, 32'h0000_0000);
    check("mid_instr", instruction, 32'h0000_0013);
    tick();
    check("mid_valid2", {31'd0, instr_valid}, 32'd0);

    // PC wrap-around on the second instance
    rst2 = 1'b0;
    tick();
    check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_hold", pc2, 32'hFFFF_FFFC);
    check("wrap_instr", instruction2, 32'h1234_5678);
    tick();
    check("wrap_pc_next", pc2, 32'h0000_0000);
    check("wrap_count", instr_count2, 32'd1);
    check("wrap_fault", {31'd0, fault2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
